// File: rtl/vgasim_pkg.sv
// Shared frame-buffer types: grant encoding, address/pixel widths and write-buffer entry.
package vgasim_pkg;

  localparam int unsigned FB_AW = 17;
  localparam int unsigned PIX_W = 24;

  typedef enum logic [1:0] {
    G_IDLE  = 2'd0,
    G_READ  = 2'd1,
    G_WRITE = 2'd2
  } gnt_e;

  typedef struct packed {
    logic [FB_AW-1:0] addr;
    logic [PIX_W-1:0] data;
  } wr_entry_t;

  function automatic logic addr_in_fb(input logic [FB_AW-1:0] addr, input int unsigned size);
    return 32'(addr) < size;
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write buffer for the frame-buffer port; DEPTH must be a power of two, >= 2.
module fb_wr_fifo
  import vgasim_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  wr_entry_t  wdata,
  input  logic       pop,
  output wr_entry_t  rdata,
  output logic       full,
  output logic       empty,
  output logic [AW:0] count
);

  wr_entry_t         mem [DEPTH];
  logic      [AW:0]  wptr_q, rptr_q;
  logic              do_push, do_pop;

  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign count   = wptr_q - rptr_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer BRAM shared between display scan-out (priority) and a buffered writer.
module fb_port_arbiter
  import vgasim_pkg::*;
#(
  parameter int unsigned H_ACT       = 480,
  parameter int unsigned V_ACT       = 272,
  parameter int unsigned WFIFO_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             DE,
  input  logic             Vsync,
  input  logic             WR_VALID,
  output logic             WR_READY,
  input  logic [FB_AW-1:0] WR_ADDR,
  input  logic [PIX_W-1:0] WR_DATA,
  output logic             BRAM_EN,
  output logic             BRAM_WE,
  output logic [FB_AW-1:0] BRAM_ADDR,
  output logic [PIX_W-1:0] BRAM_WDATA,
  input  logic [PIX_W-1:0] BRAM_RDATA,
  output logic             PIX_VALID,
  output logic [7:0]       R,
  output logic [7:0]       G,
  output logic [7:0]       B,
  output logic [7:0]       FRAME_CNT,
  output logic             WR_DROP
);

  localparam int unsigned     FB_SIZE = H_ACT * V_ACT;
  localparam logic [FB_AW-1:0] LAST   = FB_AW'(FB_SIZE - 1);
  localparam int unsigned     CW      = $clog2(WFIFO_DEPTH) + 1;

  gnt_e             gnt_q, gnt_d;
  logic [FB_AW-1:0] disp_q;
  logic [7:0]       frame_q;
  logic             vs_q, pv_q, drop_q;
  logic             accept, wr_push, wr_pop, frame_start, fifo_busy_nxt;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_cnt;
  wr_entry_t        fifo_head, fifo_in;

  assign fifo_in     = '{addr: WR_ADDR, data: WR_DATA};
  assign WR_READY    = !fifo_full;
  assign accept      = WR_VALID && WR_READY;
  assign wr_push     = accept && addr_in_fb(WR_ADDR, FB_SIZE);
  assign wr_pop      = (gnt_q == G_WRITE);
  assign frame_start = vs_q && !Vsync;

  fb_wr_fifo #(
    .DEPTH (WFIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (wr_push),
    .wdata (fifo_in),
    .pop   (wr_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Grant looks at post-pop/push occupancy so a G_WRITE never lands on an empty buffer.
  assign fifo_busy_nxt = wr_push || (!fifo_empty && (!wr_pop || fifo_cnt != CW'(1)));

  always_comb begin
    gnt_d = G_IDLE;
    if (DE)                 gnt_d = G_READ;
    else if (fifo_busy_nxt) gnt_d = G_WRITE;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      gnt_q   <= G_IDLE;
      disp_q  <= '0;
      frame_q <= '0;
      vs_q    <= 1'b1;
      pv_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      gnt_q <= gnt_d;
      vs_q  <= Vsync;
      pv_q  <= DE;
      if (accept && !addr_in_fb(WR_ADDR, FB_SIZE)) drop_q <= 1'b1;
      if (frame_start) begin
        disp_q  <= '0;
        frame_q <= frame_q + 8'd1;
      end else if (gnt_q == G_READ) begin
        disp_q <= (disp_q == LAST) ? '0 : disp_q + 1'b1;
      end
    end
  end

  always_comb begin
    BRAM_EN    = 1'b0;
    BRAM_WE    = 1'b0;
    BRAM_ADDR  = '0;
    BRAM_WDATA = '0;
    unique case (gnt_q)
      G_READ: begin
        BRAM_EN   = 1'b1;
        BRAM_ADDR = disp_q;
      end
      G_WRITE: begin
        BRAM_EN    = 1'b1;
        BRAM_WE    = 1'b1;
        BRAM_ADDR  = fifo_head.addr;
        BRAM_WDATA = fifo_head.data;
      end
      default: ;
    endcase
  end

  assign PIX_VALID = pv_q;
  assign R         = pv_q ? BRAM_RDATA[23:16] : 8'd0;
  assign G         = pv_q ? BRAM_RDATA[15:8]  : 8'd0;
  assign B         = pv_q ? BRAM_RDATA[7:0]   : 8'd0;
  assign FRAME_CNT = frame_q;
  assign WR_DROP   = drop_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: default-size instance plus a tiny-frame instance for wrap.
module tb_fb_port_arbiter;

  logic        CLK = 1'b0, RESET = 1'b1;
  logic        DE = 1'b0, Vsync = 1'b1, WR_VALID = 1'b0, WR_READY;
  logic [16:0] WR_ADDR = '0, BRAM_ADDR;
  logic [23:0] WR_DATA = '0, BRAM_WDATA, BRAM_RDATA = '0;
  logic        BRAM_EN, BRAM_WE, PIX_VALID, WR_DROP;
  logic [7:0]  R, G, B, FRAME_CNT;

  logic        s_de = 1'b0, s_vsync = 1'b1, s_wr_ready, s_en, s_we, s_pv, s_drop;
  logic [16:0] s_addr;
  logic [23:0] s_wdata;
  logic [7:0]  s_r, s_g, s_b, s_frame;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  fb_port_arbiter dut (
    .CLK(CLK), .RESET(RESET), .DE(DE), .Vsync(Vsync), .WR_VALID(WR_VALID),
    .WR_READY(WR_READY), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .BRAM_EN(BRAM_EN),
    .BRAM_WE(BRAM_WE), .BRAM_ADDR(BRAM_ADDR), .BRAM_WDATA(BRAM_WDATA),
    .BRAM_RDATA(BRAM_RDATA), .PIX_VALID(PIX_VALID), .R(R), .G(G), .B(B),
    .FRAME_CNT(FRAME_CNT), .WR_DROP(WR_DROP)
  );

  // 4x3 frame so the address wrap is reachable in a handful of cycles.
  fb_port_arbiter #(
    .H_ACT(4), .V_ACT(3), .WFIFO_DEPTH(2)
  ) dut_small (
    .CLK(CLK), .RESET(RESET), .DE(s_de), .Vsync(s_vsync), .WR_VALID(1'b0),
    .WR_READY(s_wr_ready), .WR_ADDR(17'd0), .WR_DATA(24'd0), .BRAM_EN(s_en),
    .BRAM_WE(s_we), .BRAM_ADDR(s_addr), .BRAM_WDATA(s_wdata),
    .BRAM_RDATA(24'h010203), .PIX_VALID(s_pv), .R(s_r), .G(s_g), .B(s_b),
    .FRAME_CNT(s_frame), .WR_DROP(s_drop)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    BRAM_RDATA = 24'hFFEEDD;
    checks++;
    if (WR_READY !== 1'b1 || BRAM_EN !== 1'b0 || BRAM_WE !== 1'b0 || BRAM_ADDR !== 17'd0 ||
        BRAM_WDATA !== 24'd0) begin
      errors++;
      $display("FAIL reset_port: rdy=%b en=%b we=%b addr=%0d wd=%h, want 1 0 0 0 0",
               WR_READY, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_WDATA);
    end
    checks++;
    if (PIX_VALID !== 1'b0 || {R, G, B} !== 24'd0 || FRAME_CNT !== 8'd0 || WR_DROP !== 1'b0) begin
      errors++;
      $display("FAIL reset_pix: pv=%b rgb=%h frame=%0d drop=%b, want 0 0 0 0",
               PIX_VALID, {R, G, B}, FRAME_CNT, WR_DROP);
    end
  endtask

  task automatic test_display;
    Vsync = 1'b0;
    tick();
    checks++;
    if (FRAME_CNT !== 8'd1 || BRAM_EN !== 1'b0) begin
      errors++;
      $display("FAIL frame_start: frame=%0d en=%b, want 1 0", FRAME_CNT, BRAM_EN);
    end
    Vsync = 1'b1;
    DE = 1'b1;
    BRAM_RDATA = 24'hA1B2C3;
    for (int k = 0; k < 480; k++) begin
      tick();
      checks++;
      if (BRAM_ADDR !== 17'(k) || BRAM_EN !== 1'b1 || BRAM_WE !== 1'b0 || PIX_VALID !== 1'b1) begin
        errors++;
        $display("FAIL scan_read[%0d]: addr=%0d en=%b we=%b pv=%b, want %0d 1 0 1",
                 k, BRAM_ADDR, BRAM_EN, BRAM_WE, PIX_VALID, k);
      end
    end
    checks++;
    if (R !== 8'hA1 || G !== 8'hB2 || B !== 8'hC3) begin
      errors++;
      $display("FAIL scan_rgb: rgb=%h%h%h, want a1b2c3", R, G, B);
    end
    DE = 1'b0;
    tick();
    checks++;
    if (PIX_VALID !== 1'b0 || BRAM_EN !== 1'b0 || {R, G, B} !== 24'd0) begin
      errors++;
      $display("FAIL scan_end: pv=%b en=%b rgb=%h, want 0 0 0", PIX_VALID, BRAM_EN, {R, G, B});
    end
  endtask

  task automatic test_writes_during_de;
    DE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      WR_VALID = 1'b1;
      WR_ADDR  = 17'(10 + i);
      WR_DATA  = 24'h5A0000 + 24'(i);
      tick();
      checks++;
      if (WR_READY !== (i < 3) || BRAM_WE !== 1'b0) begin
        errors++;
        $display("FAIL fill_ready[%0d]: rdy=%b we=%b, want %b 0", i, WR_READY, BRAM_WE, i < 3);
      end
    end
    WR_VALID = 1'b0;
    tick();
    checks++;
    if (BRAM_WE !== 1'b0 || BRAM_EN !== 1'b1 || WR_READY !== 1'b0) begin
      errors++;
      $display("FAIL held_during_de: we=%b en=%b rdy=%b, want 0 1 0", BRAM_WE, BRAM_EN, WR_READY);
    end
    DE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (BRAM_EN !== 1'b1 || BRAM_WE !== 1'b1 || BRAM_ADDR !== 17'(10 + i) ||
          BRAM_WDATA !== 24'h5A0000 + 24'(i) || WR_READY !== (i != 0)) begin
        errors++;
        $display("FAIL drain[%0d]: en=%b we=%b addr=%0d wd=%h rdy=%b, want 1 1 %0d %h %b",
                 i, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_WDATA, WR_READY,
                 10 + i, 24'h5A0000 + 24'(i), i != 0);
      end
    end
    tick();
    checks++;
    if (BRAM_EN !== 1'b0 || BRAM_WE !== 1'b0 || WR_READY !== 1'b1) begin
      errors++;
      $display("FAIL drain_done: en=%b we=%b rdy=%b, want 0 0 1", BRAM_EN, BRAM_WE, WR_READY);
    end
  endtask

  task automatic test_drop;
    WR_VALID = 1'b1;
    WR_ADDR  = 17'd130560;
    WR_DATA  = 24'h123456;
    tick();
    WR_VALID = 1'b0;
    checks++;
    if (WR_DROP !== 1'b1 || BRAM_WE !== 1'b0) begin
      errors++;
      $display("FAIL drop_set: drop=%b we=%b, want 1 0", WR_DROP, BRAM_WE);
    end
    tick();
    checks++;
    if (BRAM_WE !== 1'b0 || WR_DROP !== 1'b1) begin
      errors++;
      $display("FAIL drop_no_write: we=%b drop=%b, want 0 1", BRAM_WE, WR_DROP);
    end
    WR_VALID = 1'b1;
    WR_ADDR  = 17'd130559;
    WR_DATA  = 24'hABCDEF;
    tick();
    WR_VALID = 1'b0;
    checks++;
    if (BRAM_WE !== 1'b1 || BRAM_ADDR !== 17'd130559 || BRAM_WDATA !== 24'hABCDEF ||
        WR_DROP !== 1'b1) begin
      errors++;
      $display("FAIL last_addr_write: we=%b addr=%0d wd=%h drop=%b, want 1 130559 abcdef 1",
               BRAM_WE, BRAM_ADDR, BRAM_WDATA, WR_DROP);
    end
    tick();
    checks++;
    if (BRAM_WE !== 1'b0 || WR_DROP !== 1'b1) begin
      errors++;
      $display("FAIL drop_sticky: we=%b drop=%b, want 0 1", BRAM_WE, WR_DROP);
    end
  endtask

  task automatic test_wrap;
    s_de = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++;
      if (s_addr !== 17'((k - 1) % 12) || s_en !== 1'b1 || s_we !== 1'b0) begin
        errors++;
        $display("FAIL wrap_read[%0d]: addr=%0d en=%b we=%b, want %0d 1 0",
                 k, s_addr, s_en, s_we, (k - 1) % 12);
      end
    end
    s_vsync = 1'b0;
    tick();
    checks++;
    if (s_addr !== 17'd0 || s_frame !== 8'd1) begin
      errors++;
      $display("FAIL midline_vsync: addr=%0d frame=%0d, want 0 1", s_addr, s_frame);
    end
    s_vsync = 1'b1;
    tick();
    checks++;
    if (s_addr !== 17'd1 || s_frame !== 8'd1) begin
      errors++;
      $display("FAIL after_vsync: addr=%0d frame=%0d, want 1 1", s_addr, s_frame);
    end
    s_de = 1'b0;
    tick();
  endtask

  task automatic test_reset_flush;
    int we_seen;
    DE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      WR_VALID = 1'b1;
      WR_ADDR  = 17'(20 + i);
      WR_DATA  = 24'h777700 + 24'(i);
      tick();
    end
    WR_VALID = 1'b0;
    #2 RESET = 1'b1;
    #1;
    checks++;
    if (BRAM_EN !== 1'b0 || WR_READY !== 1'b1 || FRAME_CNT !== 8'd0 || WR_DROP !== 1'b0 ||
        PIX_VALID !== 1'b0 || {R, G, B} !== 24'd0) begin
      errors++;
      $display("FAIL reset_async: en=%b rdy=%b frame=%0d drop=%b pv=%b rgb=%h, want 0 1 0 0 0 0",
               BRAM_EN, WR_READY, FRAME_CNT, WR_DROP, PIX_VALID, {R, G, B});
    end
    tick();
    tick();
    RESET = 1'b0;
    DE    = 1'b0;
    we_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (BRAM_WE === 1'b1) we_seen++;
    end
    checks++;
    if (we_seen !== 0) begin
      errors++;
      $display("FAIL flush_no_write: write cycles=%0d, want 0", we_seen);
    end
    checks++;
    if (WR_READY !== 1'b1 || FRAME_CNT !== 8'd0 || WR_DROP !== 1'b0 || BRAM_EN !== 1'b0) begin
      errors++;
      $display("FAIL flush_state: rdy=%b frame=%0d drop=%b en=%b, want 1 0 0 0",
               WR_READY, FRAME_CNT, WR_DROP, BRAM_EN);
    end
  endtask

  task automatic test_full_pop;
    logic [16:0] exp_addr;
    DE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      WR_VALID = 1'b1;
      WR_ADDR  = 17'(40 + i);
      WR_DATA  = 24'hC00000 + 24'(40 + i);
      tick();
    end
    checks++;
    if (WR_READY !== 1'b0) begin
      errors++;
      $display("FAIL full_flag: rdy=%b, want 0", WR_READY);
    end
    DE      = 1'b0;
    WR_ADDR = 17'd44;
    WR_DATA = 24'hC00000 + 24'd44;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 2) WR_VALID = 1'b0;
      exp_addr = 17'(40 + i);
      checks++;
      if (BRAM_WE !== 1'b1 || BRAM_ADDR !== exp_addr ||
          BRAM_WDATA !== 24'hC00000 + 24'(exp_addr) || WR_READY !== (i != 0)) begin
        errors++;
        $display("FAIL full_drain[%0d]: we=%b addr=%0d wd=%h rdy=%b, want 1 %0d %h %b",
                 i, BRAM_WE, BRAM_ADDR, BRAM_WDATA, WR_READY, exp_addr,
                 24'hC00000 + 24'(exp_addr), i != 0);
      end
    end
    tick();
    checks++;
    if (BRAM_WE !== 1'b0 || WR_READY !== 1'b1) begin
      errors++;
      $display("FAIL full_done: we=%b rdy=%b, want 0 1", BRAM_WE, WR_READY);
    end
  endtask

  initial begin
    tick();
    tick();
    RESET = 1'b0;
    tick();
    test_reset();
    test_display();
    test_writes_during_de();
    test_drop();
    test_wrap();
    test_reset_flush();
    test_full_pop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
